gold_code_correlator: RTL and testbench
=======================================

// Module: gold_code_correlator
// PURPOSE
// Despreader that sits downstream of the Gold code generator.
// It stores one reference Gold code period, loaded serially from the generator's chip output.
// It slides the received chip stream across that reference and produces a signed correlation
// value for every chip.
// It detects peaks, locks to the code period, and emits one recovered data bit per period.
// PARAMETERS
// N        63  code length in chips (2^6-1, matches the 6-bit LFSR generators)
// THRESH   48  |corr| >= THRESH counts as a peak
// MISS_MAX 3   consecutive missed peaks while locked before falling back to search
// CW       $clog2(N+1)+1 (localparam) correlation width, signed; 7 for N=63
// PORTS
// clkin      in   1   clock, all logic on rising edge
// rst        in   1   synchronous reset, active-high
// ref_bit    in   1   reference code chip (Gold code generator output)
// ref_we     in   1   ref_bit is valid this cycle
// chip_in    in   1   received chip
// chip_valid in   1   chip_in is valid this cycle
// ready      out  1   reference fully loaded; chips are being accepted
// corr       out  CW  signed correlation, range -N..+N
// corr_valid out  1   one-cycle pulse, corr is updated
// peak       out  1   one-cycle pulse, with corr_valid, when |corr| >= THRESH and the peak is used
// data_bit   out  1   recovered bit: 1 if corr > 0, else 0
// data_valid out  1   one-cycle pulse, data_bit is updated
// locked     out  1   high while in LOCKED
// BEHAVIOUR
// - Reset
//   - rst dominates all other inputs.
//   - All outputs go to 0; ref_reg, window and all counters clear; state = LOAD.
// - State LOAD
//   - Each ref_we cycle: ref_reg <= {ref_reg[N-2:0], ref_bit}; ref_cnt++.
//   - chip_valid is ignored in LOAD.
//   - On the Nth write: go to FILL, ready=1 next cycle.
// - State FILL
//   - Each chip_valid cycle: window <= {window[N-2:0], chip_in}; fill_cnt++.
//   - On the Nth chip: go to SEARCH.
// - Correlation (FILL on the Nth chip, SEARCH, LOCKED)
//   - Computed from the post-shift window: corr = N - 2*popcount(window_next ^ ref_reg).
//   - Registered with 1-cycle latency: corr and corr_valid appear the cycle after chip_valid.
//   - No corr_valid for the first N-1 chips after entering FILL.
// - State SEARCH
//   - First corr with |corr| >= THRESH: peak=1, data_bit=(corr>0), data_valid=1.
//   - Same event: phase counter cleared to 0, miss_cnt=0, state -> LOCKED (locked=1 the same cycle as peak).
// - State LOCKED
//   - phase increments on every chip_valid and wraps N-1 -> 0.
//   - Evaluation happens only on the chip that brings phase to 0, i.e. exactly N chips after the previous evaluation.
//   - Hit (|corr| >= THRESH): peak=1, data_valid=1, data_bit=(corr>0), miss_cnt=0.
//   - Miss: data_valid=1, data_bit=(corr>0) (soft decision), peak=0, miss_cnt++.
//   - When miss_cnt reaches MISS_MAX: state -> SEARCH and locked=0 on that same output cycle.
//   - Peaks at any other phase are ignored: no peak pulse.
// - Gaps: cycles without chip_valid freeze window, phase and all outputs except pulses, which drop to 0.
// - Reload: ref_we in any state other than LOAD forces LOAD.
//   - That write counts as reference chip 1.
//   - window, fill_cnt, phase and miss_cnt clear; ready, locked drop to 0 next cycle.
// - Simultaneous ref_we and chip_valid: ref_we wins, the chip is dropped.
// - corr is saturation-free: it is exact by construction within -N..+N, two's complement, CW bits.
// TESTING
// T1 Load the Gold ref (63 ref_we), then feed the same 63 chips:
//    - no corr_valid for chips 1..62;
//    - after chip 63: corr=+63, peak=1, data_bit=1, data_valid=1, locked=1.
// T2 Locked, next period fed inverted:
//    - corr=-63 exactly 63 chips later, peak=1, data_bit=0.
// T3 Ref with 32 ones, feed 63 zero chips:
//    - corr=-1, peak=0, state stays SEARCH, data_valid never pulses.
// T4 Locked, then 3 periods of all-zero chips with the same ref:
//    - 3 data_valid pulses with peak=0;
//    - locked=0 on the 3rd; a later correct period relocks.
// T5 ref_we mid-LOCKED, chip_valid asserted in the same cycle:
//    - locked=0 and ready=0 next cycle; the chip is dropped;
//    - corr_valid is absent until 63 ref writes plus 63 chips complete.
// T6 rst pulse mid-FILL:
//    - all outputs 0, ready=0;
//    - a subsequent T1 sequence passes unchanged.

Source files
------------

// File: rtl/gold_code_correlator.sv
// Despreader for an N-chip Gold code: holds a serially loaded reference period,
// correlates the received chip stream against it, locks on peaks and emits one bit per period.
module gold_code_correlator #(
  parameter int N        = 63,
  parameter int THRESH   = 48,
  parameter int MISS_MAX = 3
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic                          ref_bit,
  input  logic                          ref_we,
  input  logic                          chip_in,
  input  logic                          chip_valid,
  output logic                          ready,
  output logic signed [$clog2(N+1):0]   corr,
  output logic                          corr_valid,
  output logic                          peak,
  output logic                          data_bit,
  output logic                          data_valid,
  output logic                          locked
);

  localparam int CW   = $clog2(N + 1) + 1;
  localparam int CNTW = $clog2(N + 1);
  localparam int MW   = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FILL   = 2'd1,
    SEARCH = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [N-1:0]        ref_reg, window, window_next;
  logic [CNTW-1:0]     ref_cnt, fill_cnt, phase;
  logic [MW-1:0]       miss_cnt;
  logic [CW-1:0]       pop, mag;
  logic signed [CW-1:0] corr_next;
  logic                is_peak, chip_ok, last_phase;
  logic                corr_upd, data_upd, peak_upd;

  // Correlation is taken over the window as it will look after this chip shifts in.
  always_comb begin
    window_next = {window[N-2:0], chip_in};
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(window_next[i] ^ ref_reg[i]);
    end
    corr_next  = CW'(N) - (pop << 1);
    mag        = corr_next[CW-1] ? CW'(-corr_next) : CW'(corr_next);
    is_peak    = (mag >= CW'(THRESH));
    chip_ok    = chip_valid && !ref_we && (state != LOAD);
    last_phase = (phase == CNTW'(N - 1));
  end

  always_comb begin
    state_next = state;
    corr_upd   = 1'b0;
    data_upd   = 1'b0;
    peak_upd   = 1'b0;
    if (ref_we) begin
      if (state != LOAD) begin
        state_next = LOAD;
      end else if (ref_cnt == CNTW'(N - 1)) begin
        state_next = FILL;
      end
    end else if (chip_valid) begin
      case (state)
        FILL: begin
          if (fill_cnt == CNTW'(N - 1)) begin
            corr_upd = 1'b1;
            if (is_peak) begin
              data_upd   = 1'b1;
              peak_upd   = 1'b1;
              state_next = LOCKED;
            end else begin
              state_next = SEARCH;
            end
          end
        end
        SEARCH: begin
          corr_upd = 1'b1;
          if (is_peak) begin
            data_upd   = 1'b1;
            peak_upd   = 1'b1;
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          corr_upd = 1'b1;
          // Only the chip that completes a code period is evaluated while locked.
          if (last_phase) begin
            data_upd = 1'b1;
            peak_upd = is_peak;
            if (!is_peak && miss_cnt == MW'(MISS_MAX - 1)) begin
              state_next = SEARCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      ref_reg    <= '0;
      window     <= '0;
      ref_cnt    <= '0;
      fill_cnt   <= '0;
      phase      <= '0;
      miss_cnt   <= '0;
      corr       <= '0;
      corr_valid <= 1'b0;
      peak       <= 1'b0;
      data_bit   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      corr_valid <= 1'b0;
      peak       <= 1'b0;
      data_valid <= 1'b0;
      if (ref_we) begin
        ref_reg <= {ref_reg[N-2:0], ref_bit};
        if (state == LOAD) begin
          ref_cnt <= (ref_cnt == CNTW'(N - 1)) ? '0 : ref_cnt + CNTW'(1);
        end else begin
          // A reload write is the first chip of the new reference.
          ref_cnt  <= CNTW'(1);
          window   <= '0;
          fill_cnt <= '0;
          phase    <= '0;
          miss_cnt <= '0;
        end
      end else if (chip_ok) begin
        window <= window_next;
        if (state == FILL) begin
          fill_cnt <= fill_cnt + CNTW'(1);
        end
        if (state == LOCKED) begin
          phase <= last_phase ? '0 : phase + CNTW'(1);
        end else begin
          phase <= '0;
        end
        if (state == LOCKED && last_phase) begin
          miss_cnt <= (is_peak || miss_cnt == MW'(MISS_MAX - 1)) ? '0 : miss_cnt + MW'(1);
        end else if (state != LOCKED) begin
          miss_cnt <= '0;
        end
        if (corr_upd) begin
          corr       <= corr_next;
          corr_valid <= 1'b1;
        end
        if (data_upd) begin
          data_bit   <= !corr_next[CW-1] && (corr_next != '0);
          data_valid <= 1'b1;
          peak       <= peak_upd;
        end
      end
    end
  end

  assign ready  = (state != LOAD);
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_gold_code_correlator.sv
// Bench for gold_code_correlator: directed scenarios plus randomized periods, every cycle
// compared against a queue-based reference model of the despreader.
module tb_gold_code_correlator;

  localparam int N        = 63;
  localparam int THRESH   = 48;
  localparam int MISS_MAX = 3;

  localparam int M_LOAD   = 0;
  localparam int M_FILL   = 1;
  localparam int M_SEARCH = 2;
  localparam int M_LOCKED = 3;

  logic clkin = 1'b0;
  logic rst, ref_bit, ref_we, chip_in, chip_valid;
  logic ready, corr_valid, peak, data_bit, data_valid, locked;
  logic signed [6:0] corr;

  int n_vec = 0;
  int n_err = 0;

  bit refq[$];
  bit winq[$];
  int m_mode  = M_LOAD;
  int m_since = 0;
  int m_miss  = 0;
  int e_cv = 0, e_pk = 0, e_dv = 0, e_db = 0, e_corr = 0;
  bit refpat[N];

  always #5 clkin = ~clkin;

  gold_code_correlator #(.N(N), .THRESH(THRESH), .MISS_MAX(MISS_MAX)) dut (
    .clkin(clkin), .rst(rst), .ref_bit(ref_bit), .ref_we(ref_we),
    .chip_in(chip_in), .chip_valid(chip_valid), .ready(ready), .corr(corr),
    .corr_valid(corr_valid), .peak(peak), .data_bit(data_bit),
    .data_valid(data_valid), .locked(locked)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Agreement score: +1 per matching chip pair, -1 per mismatch, oldest chip against oldest ref.
  function automatic int modelCorr();
    int s = 0;
    for (int j = 0; j < N; j++) s += (refq[j] == winq[j]) ? 1 : -1;
    return s;
  endfunction

  task automatic modelStep(input bit r, input bit rw, input bit rb, input bit cv, input bit ci);
    int c;
    bit hit;
    e_cv = 0; e_pk = 0; e_dv = 0;
    if (r) begin
      refq.delete(); winq.delete();
      m_mode = M_LOAD; m_since = 0; m_miss = 0; e_corr = 0; e_db = 0;
    end else if (rw) begin
      if (m_mode != M_LOAD) begin
        refq.delete(); winq.delete();
        m_mode = M_LOAD;
      end
      refq.push_back(rb);
      if (refq.size() == N) m_mode = M_FILL;
    end else if (cv && m_mode != M_LOAD) begin
      winq.push_back(ci);
      if (winq.size() > N) void'(winq.pop_front());
      if (winq.size() == N) begin
        c = modelCorr();
        hit = (c >= THRESH) || (-c >= THRESH);
        e_cv = 1; e_corr = c;
        if (m_mode == M_LOCKED) begin
          m_since++;
          if (m_since == N) begin
            m_since = 0; e_dv = 1; e_db = (c > 0);
            if (hit) begin
              e_pk = 1; m_miss = 0;
            end else begin
              m_miss++;
              if (m_miss == MISS_MAX) begin m_mode = M_SEARCH; m_miss = 0; end
            end
          end
        end else if (hit) begin
          e_pk = 1; e_dv = 1; e_db = (c > 0);
          m_mode = M_LOCKED; m_since = 0; m_miss = 0;
        end else begin
          m_mode = M_SEARCH;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rw, input bit rb, input bit cv, input bit ci);
    rst = r; ref_we = rw; ref_bit = rb; chip_valid = cv; chip_in = ci;
    @(posedge clkin);
    #1;
    modelStep(r, rw, rb, cv, ci);
    checkOutput("ready", ready, (m_mode != M_LOAD));
    checkOutput("locked", locked, (m_mode == M_LOCKED));
    checkOutput("corr_valid", corr_valid, e_cv);
    checkOutput("peak", peak, e_pk);
    checkOutput("data_valid", data_valid, e_dv);
    checkOutput("corr", corr, e_corr);
    checkOutput("data_bit", data_bit, e_db);
  endtask

  task automatic loadRef();
    for (int i = 0; i < N; i++) applyStimulus(0, 1, refpat[i], 0, 0);
  endtask

  // kind: 0 reference, 1 inverted, 2 all zeros, 3 random chips
  task automatic feedPeriod(input int kind, input int gap_pct, input int nflip, input int rnoise);
    bit b;
    for (int i = 0; i < N; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) applyStimulus(0, 0, 0, 0, 0);
      case (kind)
        0: b = refpat[i];
        1: b = !refpat[i];
        2: b = 1'b0;
        default: b = 1'($urandom);
      endcase
      if (i < nflip) b = !b;
      if (rnoise > 0 && $urandom_range(N - 1) < rnoise) b = !b;
      applyStimulus(0, 0, 0, 1, b);
    end
  endtask

  task automatic makeBalanced();
    int k;
    bit t;
    for (int i = 0; i < N; i++) refpat[i] = (i < 32);
    for (int i = N - 1; i > 0; i--) begin
      k = $urandom_range(i);
      t = refpat[i]; refpat[i] = refpat[k]; refpat[k] = t;
    end
  endtask

  initial begin
    int kind;
    rst = 1; ref_we = 0; ref_bit = 0; chip_valid = 0; chip_in = 0;
    $display("[TB] start");
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_corr", corr, 0);

    // Load, then matching period: first correlation lands on chip 63
    makeBalanced();
    loadRef();
    feedPeriod(0, 0, 0, 0);
    checkOutput("t1_corr", corr, 63);
    checkOutput("t1_peak", peak, 1);
    checkOutput("t1_bit", data_bit, 1);
    checkOutput("t1_locked", locked, 1);

    feedPeriod(1, 20, 0, 0);
    checkOutput("t2_corr", corr, -63);
    checkOutput("t2_peak", peak, 1);
    checkOutput("t2_bit", data_bit, 0);

    // Threshold boundary: 7 flips gives 49 (hit), 8 flips gives 47 (miss)
    feedPeriod(0, 0, 7, 0);
    checkOutput("thr49_corr", corr, 49);
    checkOutput("thr49_peak", peak, 1);
    feedPeriod(0, 0, 8, 0);
    checkOutput("thr47_corr", corr, 47);
    checkOutput("thr47_peak", peak, 0);
    checkOutput("thr47_dv", data_valid, 1);
    feedPeriod(0, 0, 0, 0);

    for (int p = 0; p < 3; p++) feedPeriod(2, 0, 0, 0);
    checkOutput("t4_dv", data_valid, 1);
    checkOutput("t4_peak", peak, 0);
    checkOutput("t4_locked", locked, 0);
    feedPeriod(0, 0, 0, 0);
    checkOutput("t4_relock", locked, 1);

    // Reload collides with a chip mid-lock
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, refpat[i]);
    applyStimulus(0, 1, refpat[0], 1, 1);
    checkOutput("t5_locked", locked, 0);
    checkOutput("t5_ready", ready, 0);
    for (int i = 1; i < N; i++) applyStimulus(0, 1, refpat[i], 0, 0);
    feedPeriod(0, 0, 0, 0);
    checkOutput("t5_cv", corr_valid, 1);
    checkOutput("t5_corr", corr, 63);

    applyStimulus(1, 0, 0, 0, 0);
    loadRef();
    feedPeriod(2, 10, 0, 0);
    checkOutput("t3_corr", corr, -1);
    checkOutput("t3_peak", peak, 0);
    checkOutput("t3_locked", locked, 0);

    applyStimulus(1, 0, 0, 0, 0);
    loadRef();
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 1, refpat[i]);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("t6_ready", ready, 0);
    checkOutput("t6_corr", corr, 0);
    loadRef();
    feedPeriod(0, 0, 0, 0);
    checkOutput("t6_corr_after", corr, 63);
    checkOutput("t6_locked", locked, 1);

    // Randomized traffic with an arbitrary reference and phase offset
    for (int i = 0; i < N; i++) refpat[i] = 1'($urandom);
    applyStimulus(1, 0, 0, 0, 0);
    loadRef();
    repeat ($urandom_range(1, N - 1)) applyStimulus(0, 0, 0, 1, 1'($urandom));
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(99);
      if (kind < 40)      feedPeriod(0, 25, 0, $urandom_range(5));
      else if (kind < 75) feedPeriod(1, 25, 0, $urandom_range(5));
      else if (kind < 90) feedPeriod(3, 10, 0, 0);
      else                feedPeriod(2, 10, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
